namco_io_multi: RTL and testbench

Parametrised custom I/O chip emulation for the Namco 6809-era boards. It serves NCHIP nibble-wide shared-RAM I/O chips behind one CPU port. A frame-synchronous engine refreshes each chip's RAM from player controls, DIP switches and a shared BCD credit counter, according to a per-chip mode nibble. It sits between the main-CPU address decoder and the MiSTer input/DIP buses, and is the multi-chip successor to the single-chip IOCTRL.

---
 rtl/namco_io_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_namco_io_multi.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/namco_io_multi.sv
// namco_io_multi: multi-chip Namco custom I/O emulation with a shared CPU port.
// Each chip is 16 nibbles of flop RAM. The frame engine refreshes every chip
// according to its mode nibble (8). Coins-per-credit values live in nibbles 9/10.
// Optional feature: define IO_COIN_COUNTER_EN to add the COIN_PULSE output.
module namco_io_multi #(
    parameter int unsigned NCHIP      = 2,
    parameter int unsigned NCOIN      = 2,
    parameter int unsigned CREDIT_MAX = 99
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       UPDATE,
    input  logic                       ENABLE,
    input  logic                       WR,
    input  logic [3+$clog2(NCHIP):0]   ADRS,
    input  logic [7:0]                 IN,
    output logic [7:0]                 OUT,
    input  logic [NCOIN-1:0]           COIN,
    input  logic [1:0]                 START,
    input  logic [11:0]                STK,
    input  logic [16*NCHIP-1:0]        SW,
    input  logic [23:0]                DIPSW,
`ifdef IO_COIN_COUNTER_EN
    output logic [NCOIN-1:0]           COIN_PULSE,
`endif
    output logic                       BUSY
);
    localparam int unsigned CW    = $clog2(NCHIP);
    localparam int unsigned AW    = CW + 4;
    localparam int unsigned DEPTH = NCHIP * 16;

    typedef enum logic [3:0] {
        StIdle, StSnap, StLoad, StCalc,
        StWr0, StWr1, StWr2, StWr3, StWr4, StWr5, StNext
    } state_e;

    state_e state_q, state_d;
    logic   advance;

    logic [3:0]          mem_q [DEPTH];
    logic [3:0]          out_q;
    logic                update_q;
    logic [CW-1:0]       chip_q;
    logic [3:0]          mode_q;
    logic                calc_done_q;
    logic [6:0]          credit_q;
    logic [3:0]          coin_cnt_q [NCOIN];
    logic [1:0]          acc_q;

    // Frame snapshot and the previous frame's snapshot (for edge detection)
    logic [NCOIN-1:0]    coin_s, coin_p;
    logic [1:0]          start_s, start_p;
    logic [11:0]         stk_s;
    logic [1:0]          trig_p;
    logic [16*NCHIP-1:0] sw_s;
    logic [23:0]         dip_s;

    logic [NCOIN-1:0]    coin_edge;
    logic [1:0]          start_edge, trig_s, trig_edge;
    logic                chip_last, write_mode, do_calc;
    logic                wr_en, last_wr;
    logic [2:0]          wr_idx;
    logic [3:0]          eng_data, cpc;
    logic [6:0]          cred, tens_full, ones_full;
    logic [3:0]          cnt_d [NCOIN];
    logic [1:0]          acc;
    logic [AW-1:0]       sw_base;
    logic                unused;

    assign coin_edge  = coin_s & ~coin_p;
    assign start_edge = start_s & ~start_p;
    assign trig_s     = {stk_s[10], stk_s[4]};
    assign trig_edge  = trig_s & ~trig_p;
    assign chip_last  = (chip_q == CW'(NCHIP - 1));
    assign write_mode = (mode_q == 4'd1) || (mode_q == 4'd3) || (mode_q == 4'd4);
    assign do_calc    = (state_q == StCalc) && (mode_q == 4'd1) && !calc_done_q;
    assign BUSY       = (state_q != StIdle);
    assign OUT        = {4'hF, out_q};
    assign tens_full  = credit_q / 7'd10;
    assign ones_full  = credit_q % 7'd10;
    assign sw_base    = {chip_q, wr_idx[1:0], 2'b00};
    assign unused     = ^{IN[7:4], stk_s[5], stk_s[11], tens_full[6:4], ones_full[6:4]};

`ifdef IO_COIN_COUNTER_EN
    assign COIN_PULSE = (do_calc && !RESET) ? coin_edge : '0;
`endif

    // Decode the write-state index; the last write of a chip also advances it
    always_comb begin
        wr_en  = 1'b1;
        wr_idx = 3'd0;
        case (state_q)
            StWr0:   wr_idx = 3'd0;
            StWr1:   wr_idx = 3'd1;
            StWr2:   wr_idx = 3'd2;
            StWr3:   wr_idx = 3'd3;
            StWr4:   wr_idx = 3'd4;
            StWr5:   wr_idx = 3'd5;
            default: wr_en = 1'b0;
        endcase
        last_wr = wr_en && ((wr_idx == 3'd5) || (mode_q == 4'd3 && wr_idx == 3'd3));
    end

    // Engine next-state; write modes fold the chip advance into their final write
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            StIdle: if (UPDATE && !update_q) state_d = StSnap;
            StSnap: state_d = StLoad;
            StLoad: state_d = StCalc;
            StCalc: state_d = write_mode ? StWr0 : StNext;
            StWr0, StWr1, StWr2, StWr3, StWr4, StWr5: begin
                if (last_wr) advance = 1'b1;
                else         state_d = state_e'(state_q + 4'd1);
            end
            StNext: advance = 1'b1;
            default: state_d = StIdle;
        endcase
        if (advance) state_d = chip_last ? StIdle : StLoad;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Coin/credit/start arithmetic evaluated for the CALC cycle
    always_comb begin
        cred = credit_q;
        acc  = 2'b00;
        cpc  = 4'd1;
        for (int i = 0; i < int'(NCOIN); i++) begin
            cpc      = mem_q[{chip_q, 4'(9 + i)}];
            if (cpc == 4'd0) cpc = 4'd1;
            cnt_d[i] = coin_cnt_q[i];
            if (coin_edge[i]) begin
                if ({1'b0, coin_cnt_q[i]} + 5'd1 >= {1'b0, cpc}) begin
                    cnt_d[i] = 4'd0;
                    if (cred < 7'(CREDIT_MAX)) cred = cred + 7'd1;
                end else begin
                    cnt_d[i] = coin_cnt_q[i] + 4'd1;
                end
            end
        end
        if (start_edge[0] && cred >= 7'd1) begin
            cred   = cred - 7'd1;
            acc[0] = 1'b1;
        end
        if (start_edge[1] && cred >= 7'd2) begin
            cred   = cred - 7'd2;
            acc[1] = 1'b1;
        end
    end

    // Engine write data selected by mode and nibble index
    always_comb begin
        eng_data = 4'd0;
        case (mode_q)
            4'd1: begin
                case (wr_idx)
                    3'd0:    eng_data = tens_full[3:0];
                    3'd1:    eng_data = ones_full[3:0];
                    3'd2:    eng_data = stk_s[3:0];
                    3'd3:    eng_data = stk_s[9:6];
                    3'd4:    eng_data = {acc_q, trig_edge};
                    3'd5:    eng_data = {2'b00, trig_s};
                    default: eng_data = 4'd0;
                endcase
            end
            4'd3:    eng_data = sw_s[sw_base +: 4];
            4'd4:    eng_data = dip_s[{wr_idx, 2'b00} +: 4];
            default: eng_data = 4'd0;
        endcase
    end

    // Engine datapath: snapshot, chip sequencing, credit state, previous inputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            update_q    <= 1'b0;
            chip_q      <= '0;
            mode_q      <= 4'd0;
            calc_done_q <= 1'b0;
            credit_q    <= 7'd0;
            acc_q       <= 2'b00;
            coin_s      <= '0;
            coin_p      <= '0;
            start_s     <= 2'b00;
            start_p     <= 2'b00;
            stk_s       <= 12'd0;
            trig_p      <= 2'b00;
            sw_s        <= '0;
            dip_s       <= 24'd0;
            for (int i = 0; i < int'(NCOIN); i++) coin_cnt_q[i] <= 4'd0;
        end else begin
            update_q <= UPDATE;
            case (state_q)
                StSnap: begin
                    coin_s      <= COIN;
                    start_s     <= START;
                    stk_s       <= STK;
                    sw_s        <= SW;
                    dip_s       <= DIPSW;
                    chip_q      <= '0;
                    calc_done_q <= 1'b0;
                    acc_q       <= 2'b00;
                end
                StLoad: mode_q <= mem_q[{chip_q, 4'd8}];
                StCalc: begin
                    if (do_calc) begin
                        credit_q    <= cred;
                        coin_cnt_q  <= cnt_d;
                        acc_q       <= acc;
                        calc_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (advance) begin
                if (chip_last) begin
                    coin_p  <= coin_s;
                    start_p <= start_s;
                    trig_p  <= trig_s;
                end else begin
                    chip_q <= chip_q + CW'(1);
                end
            end
        end
    end

    // Nibble RAM; the CPU write is applied last so it wins a same-address clash
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 4'd0;
        end else begin
            if (wr_en) mem_q[{chip_q, 1'b0, wr_idx}] <= eng_data;
            if (ENABLE && WR) mem_q[ADRS] <= IN[3:0];
        end
    end

    // CPU read register: returns the pre-write nibble on a simultaneous write
    always_ff @(posedge CLK) begin
        if (RESET)       out_q <= 4'd0;
        else if (ENABLE) out_q <= mem_q[ADRS];
    end

endmodule

// File: tb/tb_namco_io_multi.sv
// Directed self-checking bench for namco_io_multi (NCHIP=2, NCOIN=2, CREDIT_MAX=99).
module tb_namco_io_multi;
    logic        CLK = 1'b0;
    logic        RESET, UPDATE, ENABLE, WR;
    logic [4:0]  ADRS;
    logic [7:0]  IN, OUT;
    logic [1:0]  COIN, START;
    logic [11:0] STK;
    logic [31:0] SW;
    logic [23:0] DIPSW;
    logic        BUSY;
`ifdef IO_COIN_COUNTER_EN
    logic [1:0]  coin_pulse;
    int          pulses;
`endif

    int checks = 0;
    int errors = 0;

    namco_io_multi #(.NCHIP(2), .NCOIN(2), .CREDIT_MAX(99)) dut (
        .CLK(CLK), .RESET(RESET), .UPDATE(UPDATE), .ENABLE(ENABLE), .WR(WR),
        .ADRS(ADRS), .IN(IN), .OUT(OUT), .COIN(COIN), .START(START), .STK(STK),
        .SW(SW), .DIPSW(DIPSW),
`ifdef IO_COIN_COUNTER_EN
        .COIN_PULSE(coin_pulse),
`endif
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [3:0] d);
        ENABLE = 1'b1; WR = 1'b1; ADRS = a; IN = {4'h0, d};
        tick();
        ENABLE = 1'b0; WR = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
        ENABLE = 1'b1; WR = 1'b0; ADRS = a;
        tick();
        ENABLE = 1'b0;
        d = OUT;
    endtask

    // One UPDATE edge, then count the cycles BUSY stays high
    task automatic run_frame(input bit reup, output int cyc);
        int n;
        n = 0;
`ifdef IO_COIN_COUNTER_EN
        pulses = 0;
`endif
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        while (BUSY === 1'b1 && n < 200) begin
`ifdef IO_COIN_COUNTER_EN
            pulses += $countones(coin_pulse);
`endif
            tick();
            n++;
            if (reup && n == 4) UPDATE = 1'b1;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL frame_timeout busy still high after %0d cycles, want idle", n);
        end
        cyc = n;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        RESET = 1'b1; UPDATE = 1'b0; ENABLE = 1'b0; WR = 1'b0; ADRS = '0; IN = '0;
        COIN = '0; START = '0; STK = '0; SW = '0; DIPSW = '0;
        repeat (3) tick();
        RESET = 1'b0;
        checks++;
        if (OUT !== 8'hF0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_state got OUT=%h BUSY=%b want F0 0", OUT, BUSY);
        end
        cpu_read(5'h08, d);
        checks++;
        if (d !== 8'hF0) begin errors++; $display("FAIL reset_mode_read got %h want F0", d); end
    endtask

    task automatic test_cpu_rw();
        logic [7:0] d;
        cpu_write(5'h13, 4'h5);
        cpu_read(5'h13, d);
        checks++;
        if (d !== 8'hF5) begin errors++; $display("FAIL cpu_rw got %h want F5", d); end
        ENABLE = 1'b1; WR = 1'b1; ADRS = 5'h13; IN = 8'h07;
        tick();
        ENABLE = 1'b0; WR = 1'b0;
        checks++;
        if (OUT !== 8'hF5) begin errors++; $display("FAIL rw_same_cycle got %h want F5", OUT); end
        cpu_read(5'h13, d);
        checks++;
        if (d !== 8'hF7) begin errors++; $display("FAIL rw_after got %h want F7", d); end
    endtask

    task automatic test_coin();
        logic [7:0] t, o, d;
        int cyc;
        cpu_write(5'h08, 4'h1);
        cpu_write(5'h09, 4'h2);
        cpu_write(5'h0A, 4'h2);
        COIN = 2'b01; run_frame(1'b0, cyc);
        checks++;
        if (cyc != 12) begin errors++; $display("FAIL frame_len_idle got %0d want 12", cyc); end
`ifdef IO_COIN_COUNTER_EN
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL coin_pulse_one got %0d want 1", pulses); end
`endif
        cpu_read(5'h00, t); cpu_read(5'h01, o);
        checks++;
        if (t !== 8'hF0 || o !== 8'hF0) begin
            errors++; $display("FAIL coin_f1 got %h/%h want F0/F0", t, o);
        end
        COIN = 2'b00; run_frame(1'b0, cyc);
        COIN = 2'b01; run_frame(1'b0, cyc);
        cpu_read(5'h00, t); cpu_read(5'h01, o);
        checks++;
        if (t !== 8'hF0 || o !== 8'hF1) begin
            errors++; $display("FAIL coin_f2 got %h/%h want F0/F1", t, o);
        end
        COIN = 2'b00; run_frame(1'b0, cyc);
        COIN = 2'b01; run_frame(1'b0, cyc);
        cpu_read(5'h00, t); cpu_read(5'h01, o);
        checks++;
        if (t !== 8'hF0 || o !== 8'hF1) begin
            errors++; $display("FAIL coin_f3 got %h/%h want F0/F1", t, o);
        end
        COIN = 2'b00; run_frame(1'b0, cyc);
        // P1 stick 3 (spare set), P2 stick C with trigger pressed
        COIN = 2'b01; STK = 12'h723; run_frame(1'b0, cyc);
        cpu_read(5'h01, o);
        checks++;
        if (o !== 8'hF2) begin errors++; $display("FAIL coin_f4 got %h want F2", o); end
        cpu_read(5'h02, d);
        checks++;
        if (d !== 8'hF3) begin errors++; $display("FAIL p1_stick got %h want F3", d); end
        cpu_read(5'h03, d);
        checks++;
        if (d !== 8'hFC) begin errors++; $display("FAIL p2_stick got %h want FC", d); end
        cpu_read(5'h04, d);
        checks++;
        if (d !== 8'hF2) begin errors++; $display("FAIL trig_edge got %h want F2", d); end
        cpu_read(5'h05, d);
        checks++;
        if (d !== 8'hF2) begin errors++; $display("FAIL trig_live got %h want F2", d); end
        COIN = 2'b00; STK = 12'h000;
    endtask

    task automatic test_start();
        logic [7:0] o, d;
        int cyc;
        START = 2'b01; run_frame(1'b0, cyc);
        START = 2'b00; run_frame(1'b0, cyc);
        START = 2'b10; run_frame(1'b0, cyc);
        cpu_read(5'h01, o); cpu_read(5'h04, d);
        checks++;
        if (o !== 8'hF1 || d !== 8'hF0) begin
            errors++; $display("FAIL start2_dropped got n1=%h n4=%h want F1 F0", o, d);
        end
        START = 2'b00; run_frame(1'b0, cyc);
        START = 2'b01; run_frame(1'b0, cyc);
        cpu_read(5'h01, o); cpu_read(5'h04, d);
        checks++;
        if (o !== 8'hF0 || d !== 8'hF4) begin
            errors++; $display("FAIL start1_paid got n1=%h n4=%h want F0 F4", o, d);
        end
        START = 2'b00; run_frame(1'b0, cyc);
    endtask

    task automatic test_saturate();
        logic [7:0] t, o, d;
        int cyc;
        cpu_write(5'h09, 4'h1);
        cpu_write(5'h0A, 4'h1);
        for (int i = 0; i < 49; i++) begin
            COIN = 2'b11; run_frame(1'b0, cyc);
            COIN = 2'b00; run_frame(1'b0, cyc);
        end
        cpu_read(5'h00, t); cpu_read(5'h01, o);
        checks++;
        if (t !== 8'hF9 || o !== 8'hF8) begin
            errors++; $display("FAIL credit_98 got %h/%h want F9/F8", t, o);
        end
        COIN = 2'b11; START = 2'b01; run_frame(1'b0, cyc);
`ifdef IO_COIN_COUNTER_EN
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL coin_pulse_two got %0d want 2", pulses); end
`endif
        cpu_read(5'h00, t); cpu_read(5'h01, o); cpu_read(5'h04, d);
        checks++;
        if (t !== 8'hF9 || o !== 8'hF8 || d !== 8'hF4) begin
            errors++; $display("FAIL saturate got %h/%h n4=%h want F9/F8 F4", t, o, d);
        end
        COIN = 2'b00; START = 2'b00;
    endtask

    task automatic test_dual_mode1();
        logic [7:0] t, o;
        int cyc;
        cpu_write(5'h18, 4'h1);
        run_frame(1'b0, cyc);
        checks++;
        if (cyc != 17) begin errors++; $display("FAIL frame_len_dual got %0d want 17", cyc); end
        cpu_read(5'h10, t); cpu_read(5'h11, o);
        checks++;
        if (t !== 8'hF9 || o !== 8'hF8) begin
            errors++; $display("FAIL mirror_credit got %h/%h want F9/F8", t, o);
        end
    endtask

    task automatic test_dip_busy();
        logic [7:0] d;
        logic [3:0] exp_n [6];
        int cyc, bad;
        exp_n = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA};
        cpu_write(5'h18, 4'h4);
        DIPSW = 24'hA54321;
        run_frame(1'b1, cyc);
        checks++;
        if (cyc != 17) begin errors++; $display("FAIL frame_len_dip got %0d want 17", cyc); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (BUSY !== 1'b0) bad++;
        end
        UPDATE = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_edge_ignored got %0d busy cycles want 0", bad); end
        for (int i = 0; i < 6; i++) begin
            cpu_read(5'(16 + i), d);
            checks++;
            if (d !== {4'hF, exp_n[i]}) begin
                errors++; $display("FAIL dip_n%0d got %h want F%h", i, d, exp_n[i]);
            end
        end
    endtask

    task automatic test_switch();
        logic [7:0] d;
        logic [3:0] exp_n [6];
        int cyc;
        exp_n = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h5, 4'hA};
        cpu_write(5'h18, 4'h3);
        SW = 32'hDCBA_0000;
        run_frame(1'b0, cyc);
        checks++;
        if (cyc != 15) begin errors++; $display("FAIL frame_len_sw got %0d want 15", cyc); end
        for (int i = 0; i < 6; i++) begin
            cpu_read(5'(16 + i), d);
            checks++;
            if (d !== {4'hF, exp_n[i]}) begin
                errors++; $display("FAIL sw_n%0d got %h want F%h", i, d, exp_n[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int bad;
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        checks++;
        if (BUSY !== 1'b0 || OUT !== 8'hF0) begin
            errors++; $display("FAIL reset_mid got BUSY=%b OUT=%h want 0 F0", BUSY, OUT);
        end
        RESET = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (BUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_mid_idle got %0d busy cycles want 0", bad); end
        cpu_read(5'h18, d);
        checks++;
        if (d !== 8'hF0) begin errors++; $display("FAIL reset_mid_mem got %h want F0", d); end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_coin();
        test_start();
        test_saturate();
        test_dual_mode1();
        test_dip_busy();
        test_switch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
